// File: rtl/pipeline_hazard_unit_if.sv
// Control bundle between the LEGv8 five-stage pipeline and pipeline_hazard_unit:
// ID-stage operand info and branch/halt requests in, hold/flush/forward controls out.
interface pipeline_hazard_unit_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNTER_WIDTH  = 32
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      mem_branch_taken;
    logic                      halt_req;

    logic                      pc_hold;
    logic                      if_id_hold;
    logic                      id_ex_bubble;
    logic                      flush_if_id;
    logic                      flush_id_ex;
    logic                      flush_ex_mem;
    logic [1:0]                fwd_a_sel;
    logic [1:0]                fwd_b_sel;
    logic                      drained;
    logic [COUNTER_WIDTH-1:0]  stall_count;
    logic [COUNTER_WIDTH-1:0]  flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_mem_read, mem_branch_taken, halt_req,
        input  pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_id_ex,
               flush_ex_mem, fwd_a_sel, fwd_b_sel, drained, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_mem_read, mem_branch_taken, halt_req,
        output pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_id_ex,
               flush_ex_mem, fwd_a_sel, fwd_b_sel, drained, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the LEGv8 five-stage pipeline: shadow scoreboard,
// load-use stall, branch flush and drain/halt. HAZARD_PERF_COUNTERS_EN enables the counters.
module pipeline_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ZERO_REG       = 31,
    parameter int COUNTER_WIDTH  = 32
) (
    input logic                   clock,
    input logic                   reset,
    pipeline_hazard_unit_if.slave hz
);
    localparam logic [REG_ADDR_WIDTH-1:0] ZREG = REG_ADDR_WIDTH'(ZERO_REG);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
    state_t state, state_nxt;

    logic                      vld_p0, wr_p0, ld_p0, rs1_used_p0, rs2_used_p0;
    logic [REG_ADDR_WIDTH-1:0] rd_p0, rs1_p0, rs2_p0;
    logic                      vld_p1, wr_p1, ld_p1;
    logic [REG_ADDR_WIDTH-1:0] rd_p1;
    logic                      vld_p2, wr_p2;
    logic [REG_ADDR_WIDTH-1:0] rd_p2;

    logic branch, load_use, id_enter, empty_nxt;
    logic vld_p0_nxt, vld_p1_nxt, vld_p2_nxt;
    logic pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, drained;

    function automatic logic writes(input logic vld, input logic wr,
                                    input logic [REG_ADDR_WIDTH-1:0] rd,
                                    input logic [REG_ADDR_WIDTH-1:0] r);
        return vld & wr & (rd == r) & (r != ZREG);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_ADDR_WIDTH-1:0] rs,
                                           input logic mem_hit, input logic wb_hit);
        if (!used)        return 2'b00;
        else if (mem_hit) return 2'b01;
        else if (wb_hit)  return 2'b10;
        else              return 2'b00;
    endfunction

    // A load sitting in MEM has no data yet, so it never forwards from EX/MEM.
    assign hz.fwd_a_sel = vld_p0 ? fwd_sel(rs1_used_p0, rs1_p0,
                                           writes(vld_p1, wr_p1, rd_p1, rs1_p0) & ~ld_p1,
                                           writes(vld_p2, wr_p2, rd_p2, rs1_p0)) : 2'b00;
    assign hz.fwd_b_sel = vld_p0 ? fwd_sel(rs2_used_p0, rs2_p0,
                                           writes(vld_p1, wr_p1, rd_p1, rs2_p0) & ~ld_p1,
                                           writes(vld_p2, wr_p2, rd_p2, rs2_p0)) : 2'b00;

    assign load_use = hz.id_valid & ld_p0 &
                      ((hz.id_rs1_used & writes(vld_p0, wr_p0, rd_p0, hz.id_rs1)) |
                       (hz.id_rs2_used & writes(vld_p0, wr_p0, rd_p0, hz.id_rs2)));

    assign branch    = hz.mem_branch_taken & (state != HALTED);
    assign id_enter  = hz.id_valid & ((state == RUN) | (state == STALL)) & ~branch;
    // Looking at next-cycle occupancy lets an empty pipeline halt in a single cycle.
    assign empty_nxt = ~(id_enter | (vld_p0 & ~branch) | vld_p1);

    assign vld_p0_nxt = id_enter & ~id_ex_bubble;
    assign vld_p1_nxt = vld_p0 & ~branch;
    assign vld_p2_nxt = vld_p1;

    always_comb begin
        state_nxt    = state;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        drained      = 1'b0;
        case (state)
            RUN: begin
                if (!branch && load_use) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_nxt    = STALL;
                end else if (hz.halt_req) begin
                    state_nxt = empty_nxt ? HALTED : DRAIN;
                end
            end
            STALL: begin
                if (!branch && hz.halt_req) state_nxt = empty_nxt ? HALTED : DRAIN;
                else                        state_nxt = RUN;
            end
            DRAIN: begin
                pc_hold     = 1'b1;
                flush_if_id = 1'b1;
                if (empty_nxt) state_nxt = HALTED;
            end
            HALTED: begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                drained    = 1'b1;
                if (!hz.halt_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (branch) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p0 <= vld_p0_nxt;
            vld_p1 <= vld_p1_nxt;
            vld_p2 <= vld_p2_nxt;
        end
    end

    // ID -> EX (p0) -> MEM (p1) -> WB (p2); payload is qualified by vld_pN only.
    always_ff @(posedge clock) begin
        rd_p0       <= hz.id_rd;
        rs1_p0      <= hz.id_rs1;
        rs2_p0      <= hz.id_rs2;
        rs1_used_p0 <= hz.id_rs1_used;
        rs2_used_p0 <= hz.id_rs2_used;
        wr_p0       <= hz.id_reg_write;
        ld_p0       <= hz.id_mem_read;
        rd_p1       <= rd_p0;
        wr_p1       <= wr_p0;
        ld_p1       <= ld_p0;
        rd_p2       <= rd_p1;
        wr_p2       <= wr_p1;
    end

    assign hz.pc_hold      = pc_hold;
    assign hz.if_id_hold   = if_id_hold;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.flush_ex_mem = flush_ex_mem;
    assign hz.drained      = drained;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] stall_cnt, flush_cnt;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_ex_bubble) stall_cnt <= sat_inc(stall_cnt);
            if (flush_ex_mem) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;
`else
    assign hz.stall_count = '0;
    assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: per-cycle expected controls are queued
// when the ID/branch/halt stimulus is driven and compared on the following falling edge.
module tb_pipeline_hazard_unit;
    localparam int RAW = 5;
    localparam int CW  = 4;

    localparam logic [10:0] IDLE   = 11'b000_000_00_00_0;
    localparam logic [10:0] STALLV = 11'b111_000_00_00_0;
    localparam logic [10:0] BRV    = 11'b000_111_00_00_0;
    localparam logic [10:0] DRAINV = 11'b100_100_00_00_0;
    localparam logic [10:0] HALTV  = 11'b110_000_00_00_1;
    localparam logic [10:0] FA10   = 11'b000_000_10_00_0;
    localparam logic [10:0] FA01   = 11'b000_000_01_00_0;
    localparam logic [10:0] FB01   = 11'b000_000_00_01_0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipeline_hazard_unit_if #(.REG_ADDR_WIDTH(RAW), .COUNTER_WIDTH(CW)) hz ();

    pipeline_hazard_unit #(.REG_ADDR_WIDTH(RAW), .ZERO_REG(31), .COUNTER_WIDTH(CW)) dut (
        .clock(clock),
        .reset(reset),
        .hz   (hz)
    );

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_t;

    sb_t           sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    always @(negedge clock) begin
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag,
                  {21'b0, hz.pc_hold, hz.if_id_hold, hz.id_ex_bubble, hz.flush_if_id,
                   hz.flush_id_ex, hz.flush_ex_mem, hz.fwd_a_sel, hz.fwd_b_sel, hz.drained},
                  {21'b0, e.exp});
        end
    end

    task automatic set_id(input logic v, input logic [RAW-1:0] rs1, input logic u1,
                          input logic [RAW-1:0] rs2, input logic u2,
                          input logic [RAW-1:0] rd, input logic rw, input logic mr);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs1_used  = u1;
        hz.id_rs2       = rs2;
        hz.id_rs2_used  = u2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step(input string tag, input logic [10:0] exp);
        sb_q.push_back('{tag, exp});
        if (reset) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (exp[8]) exp_stall = sat(exp_stall);
            if (exp[5]) exp_flush = sat(exp_flush);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_ctr(input string tag);
`ifdef HAZARD_PERF_COUNTERS_EN
        check({tag, "_stall_count"}, 32'(hz.stall_count), 32'(exp_stall));
        check({tag, "_flush_count"}, 32'(hz.flush_count), 32'(exp_flush));
`else
        check({tag, "_stall_count"}, 32'(hz.stall_count), 32'd0);
        check({tag, "_flush_count"}, 32'(hz.flush_count), 32'd0);
`endif
    endtask

    initial begin
        reset               = 1'b1;
        hz.mem_branch_taken = 1'b0;
        hz.halt_req         = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        step("rst_outputs", IDLE);
        check_ctr("rst");
        reset = 1'b0;

        // LDUR X2,[X1]; ADD X3,X2,X4
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("lu_ld", IDLE);
        set_id(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0); step("lu_stall", STALLV);
        step("lu_stall_once", IDLE);
        idle();                                  step("lu_fwd_wb", FA10);
        step("lu_idle", IDLE);

        // ADD X2,X1,X1; SUB X5,X2,X2
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0); step("fm_add", IDLE);
        set_id(1, 5'd2, 1, 5'd2, 1, 5'd5, 1, 0); step("fm_sub_id", IDLE);
        idle();                                  step("fm_mem_ab", FA01 | FB01);

        // ADD X2; ADD X2; SUB X5,X2,X3
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0); step("two_w_1", IDLE);
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0); step("two_w_2", IDLE);
        set_id(1, 5'd2, 1, 5'd3, 1, 5'd5, 1, 0); step("two_w_sub", IDLE);
        idle();                                  step("two_w_newest", FA01);

        // ADD XZR,X1,X1; SUB X5,XZR,X6; LDUR XZR then reader of XZR
        step("xzr_gap", IDLE);
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd31, 1, 0);  step("xzr_add", IDLE);
        set_id(1, 5'd31, 1, 5'd6, 1, 5'd5, 1, 0);  step("xzr_sub", IDLE);
        idle();                                    step("xzr_fwd", IDLE);
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd31, 1, 1);  step("xzr_ld", IDLE);
        set_id(1, 5'd31, 1, 5'd31, 1, 5'd3, 1, 0); step("xzr_no_stall", IDLE);

        // unused sources and invalid ID never stall
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("un_ld", IDLE);
        set_id(1, 5'd2, 0, 5'd2, 0, 5'd7, 1, 0); step("unused_no_stall", IDLE);
        idle();                                  step("unused_fwd00", IDLE);
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("inv_ld", IDLE);
        set_id(0, 5'd2, 1, 5'd2, 1, 5'd3, 1, 0); step("invalid_id_no_stall", IDLE);

        // CBZ taken in MEM while ADD X3,X2 sees a load-use on LDUR X2
        idle();                                  step("br_gap", IDLE);
        set_id(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0); step("br_cbz", IDLE);
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("br_ld", IDLE);
        set_id(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0);
        hz.mem_branch_taken = 1'b1;              step("br_over_lu", BRV);
        hz.mem_branch_taken = 1'b0;
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 0); step("br_ex_inval", IDLE);
        idle();                                  step("br_mem_inval", IDLE);
        check_ctr("br");

        // halt with three instructions in flight
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0); step("dr_i1", IDLE);
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0); step("dr_i2", IDLE);
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0);
        hz.halt_req = 1'b1;                       step("halt_entry", IDLE);
        idle();                                   step("drain1", DRAINV);
        hz.mem_branch_taken = 1'b1;               step("drain_br", DRAINV | BRV);
        hz.mem_branch_taken = 1'b0;               step("drain3", DRAINV);
        hz.mem_branch_taken = 1'b1;               step("halted_br_ignored", HALTV);
        hz.mem_branch_taken = 1'b0;
        hz.halt_req = 1'b0;                       step("halted_release", HALTV);
        step("run_after_halt", IDLE);
        check_ctr("drain");

        // halt on an empty pipeline
        hz.halt_req = 1'b1; step("halt_empty", IDLE);
        step("halted_fast", HALTV);
        hz.halt_req = 1'b0; step("release2", HALTV);
        step("run2", IDLE);

        // reset mid-DRAIN
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0); step("rd_i1", IDLE);
        idle();
        hz.halt_req = 1'b1; step("halt_entry2", IDLE);
        reset = 1'b1;       step("drain_pre_rst", DRAINV);
        reset = 1'b0;
        hz.halt_req = 1'b0; step("rst_mid_drain", IDLE);
        check_ctr("rst_drain");

        // reset mid-STALL
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("rs_ld", IDLE);
        set_id(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0); step("rs_stall", STALLV);
        reset = 1'b1;                            step("stall_rst", IDLE);
        reset = 1'b0;
        idle();                                  step("rst_mid_stall", IDLE);

        // 20 load-use stalls, one bubble each
        step("loop_gap", IDLE);
        for (int i = 0; i < 20; i++) begin
            set_id(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1); step("loop_ld", (i == 0) ? IDLE : FA10);
            set_id(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0); step("loop_stall", STALLV);
            step("loop_hold", IDLE);
        end
        idle(); step("loop_tail", FA10);
        check_ctr("loop");

        @(negedge clock);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the five-stage LEGv8 pipeline (IF, ID, EX, MEM, WB). It keeps its own scoreboard of in-flight destination registers. From that scoreboard it generates EX-stage forwarding selects, load-use stalls, and flushes on branches resolved in MEM. It also provides a drain/halt sequence so the pipeline can be quiesced without losing in-flight writes. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their hold/flush controls.

## Interface
- `REG_ADDR_WIDTH`, 5: register specifier width.
- `ZERO_REG`, 31: register index never written and never forwarded (XZR).
- `COUNTER_WIDTH`, 32: width of performance counters.

- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in REG_ADDR_WIDTH: ID source specifiers (rs2 is already Reg2Loc-muxed).
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in REG_ADDR_WIDTH: ID destination.
- `id_reg_write`, `id_mem_read` in 1: ID control bits.
- `mem_branch_taken` in 1: branch in MEM is taken, either `(Branch & zero)` or unconditional.
- `halt_req` in 1: request pipeline drain.
- `pc_hold`, `if_id_hold` out 1: freeze PC and IF/ID.
- `id_ex_bubble` out 1: load zeros into ID/EX controls.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1: zero the respective stage controls.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX ALU operand source. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
- `drained` out 1: pipeline empty and halted.
- `stall_count`, `flush_count` out COUNTER_WIDTH: performance counters (see Configuration).

## Operation
- **Scoreboard.** The unit holds shadow entries EX, MEM and WB. Each entry holds {valid, rd, reg_write, mem_read, rs1, rs2, rs1_used, rs2_used}.
  - On each clock without stall: ID→EX, EX→MEM, MEM→WB, and WB is discarded.
  - On stall: EX receives an invalid entry (bubble), while MEM and WB still advance.
- **Writer qualification.** An entry "writes r" when valid & reg_write & rd==r & r!=ZERO_REG.
- **Forwarding** (combinational from the EX entry), applied per operand:
  - Select 01 if MEM writes the source and MEM is not mem_read.
  - Else select 10 if WB writes the source.
  - Else select 00.
  - Unused sources select 00. MEM has priority over WB.
- **Load-use.** A stall is needed when EX is valid with mem_read, EX writes id_rs1 (with rs1_used) or id_rs2 (with rs2_used), and id_valid is set.
- **State machine.**
  - RUN:
    - Load-use → STALL. In the same cycle assert pc_hold, if_id_hold and id_ex_bubble.
    - halt_req → DRAIN.
  - STALL: lasts exactly one cycle; outputs are deasserted; next state is RUN, or DRAIN if halt_req is asserted. By then the load is in MEM and forwarding selects WB.
  - DRAIN:
    - pc_hold=1 and flush_if_id=1, so no new instructions enter.
    - EX, MEM and WB drain normally.
    - When all three entries are invalid → HALTED.
  - HALTED:
    - pc_hold=1, if_id_hold=1, drained=1.
    - Deasserting halt_req → RUN on the next cycle.
- **Taken branch** (mem_branch_taken=1, any state except HALTED):
  - Assert flush_if_id, flush_id_ex and flush_ex_mem combinationally in that cycle.
  - Invalidate the incoming EX entry and the entry moving into MEM.
  - Clear any pending stall. STALL→RUN; DRAIN is unchanged.
  - Branch takes precedence over load-use in the same cycle. pc_hold is forced to 0 so the branch target is loaded, except in DRAIN.

## Timing
- Reset (synchronous): all entries invalid, state RUN. All outputs read 0, counters included.
- Forwarding selects are valid in the same cycle the consumer occupies EX. Latency is zero, purely combinational from the registered entries.
- Stall and flush outputs are combinational from the ID inputs and the registered state. They must be sampled by the pipeline registers on the next rising edge.
- A load-use costs exactly 1 bubble. Back-to-back dependent loads cost 1 bubble each.
- A taken branch costs 3 flushed slots.
- halt_req to drained is at most 4 cycles in RUN (1 entry cycle plus 3 drain cycles). It is 1 cycle if the pipeline is already empty.
- Reset asserted mid-STALL or mid-DRAIN returns to RUN with all outputs 0 on the following cycle.

## Configuration
- `HAZARD_PERF_COUNTERS_EN` defined:
  - stall_count increments on every cycle with id_ex_bubble=1.
  - flush_count increments on every taken branch.
  - Both counters saturate at all-ones and do not wrap.
- Undefined: both counters are tied to 0 and no counter flops are synthesised.

## Test plan
- LDUR X2,[X1]; ADD X3,X2,X4 → exactly one cycle of pc_hold/if_id_hold/id_ex_bubble. The ADD in EX sees fwd_a_sel=10.
- ADD X2,..; SUB X5,X2,X2 → no stall. SUB in EX sees fwd_a_sel=01 and fwd_b_sel=01. Same for two writers: ADD X2; ADD X2; SUB uses X2 → 01 (newest wins).
- ADD XZR,X1,X1; SUB X5,XZR,X6 → fwd_a_sel=00, no stall.
- CBZ taken, reaching MEM while a load-use is detected in ID → three flush outputs high in the same cycle, id_ex_bubble=0, state RUN, flush_count=1.
- halt_req with 3 valid in-flight instructions → drained after 4 cycles. Releasing halt_req → pc_hold=0 next cycle.
- With `HAZARD_PERF_COUNTERS_EN` and COUNTER_WIDTH=4: 20 load-use stalls → stall_count=15. Assert reset mid-DRAIN → all outputs 0 next cycle.
